// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle WIDTH x WIDTH -> WIDTH (low word) shift-and-add multiplier.
//   It owns no adder. Each iteration it borrows the shared CPU ALU through
//   a request/grant pair. The pipeline EX stage always wins arbitration.
//
// Handshake (AluReq/AluGnt):
//   AluReq is high in every STEP cycle. An iteration retires only on a
//   cycle where AluReq && AluGnt. On a cycle without a grant, every
//   register holds and the sequencer retries on the next cycle, with no
//   timeout. AluOp1, AluOp2 and AluCtrl are combinational from registers.
//   AluRes is expected back in the same cycle.
//
// Optional feature:
//   MULSEQ_EARLY_EXIT_EN - when defined, the sequencer finishes as soon as
//   the multiplier has no set bits left, instead of always running WIDTH
//   granted steps.
//
// Ports:
//   CPU_CLK, CPU_RST_N  clock (rising edge), async active-low reset
//   Start, MulA, MulB   start pulse and operands (accepted only in IDLE)
//   Busy, Done          busy through DONE; Done is a one-cycle pulse
//   Product             low WIDTH bits of MulA*MulB, valid with Done
//   AluReq, AluGnt      ALU request/grant
//   AluOp1, AluOp2      ALU operands: accumulator, shifted multiplicand
//   AluCtrl             ALU control (always ADD)
//   AluRes              combinational ALU result
//   DbgState            current FSM state (0 IDLE, 1 STEP, 2 DONE)
module alu_mul_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             CPU_CLK,
   input  logic             CPU_RST_N,
   input  logic             Start,
   input  logic [WIDTH-1:0] MulA,
   input  logic [WIDTH-1:0] MulB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Product,
   output logic             AluReq,
   input  logic             AluGnt,
   output logic [WIDTH-1:0] AluOp1,
   output logic [WIDTH-1:0] AluOp2,
   output logic [3:0]       AluCtrl,
   input  logic [WIDTH-1:0] AluRes,
   output logic [1:0]       DbgState
);

   // This encoding must match the CPU's ADD encoding.
   localparam logic [3:0] ALU_ADD = 4'b0010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [WIDTH-1:0]   acc, acc_next;
   logic [WIDTH-1:0]   mcand, mcand_next;
   logic [WIDTH-1:0]   mplier, mplier_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [WIDTH-1:0]   product, product_next;
   logic               alu_req;
   logic               last_step;

   // Marks the granted iteration that finishes the product.
`ifdef MULSEQ_EARLY_EXIT_EN
   assign last_step = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
   assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         acc     <= acc_next;
         mcand   <= mcand_next;
         mplier  <= mplier_next;
         cnt     <= cnt_next;
         product <= product_next;
      end
   end

   always_comb begin
      state_next   = state;
      acc_next     = acc;
      mcand_next   = mcand;
      mplier_next  = mplier;
      cnt_next     = cnt;
      product_next = product;
      alu_req      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               acc_next    = '0;
               mcand_next  = MulA;
               mplier_next = MulB;
               cnt_next    = '0;
               state_next  = STEP;
            end
         end
         STEP: begin
            // Request even when mplier[0] is 0 so each iteration costs
            // exactly one grant.
            alu_req = 1'b1;
            if (AluGnt) begin
               if (mplier[0]) begin
                  acc_next = AluRes;
               end
               mcand_next  = mcand << 1;
               mplier_next = mplier >> 1;
               cnt_next    = cnt + CNT_W'(1);
               if (last_step) begin
                  // Load Product on the edge that enters DONE, so Product
                  // is already valid while Done is high.
                  product_next = mplier[0] ? AluRes : acc;
                  state_next   = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign Busy     = (state != IDLE);
   assign Done     = (state == DONE);
   assign Product  = product;
   assign AluReq   = alu_req;
   assign AluOp1   = acc;
   assign AluOp2   = mcand;
   assign AluCtrl  = ALU_ADD;
   assign DbgState = state;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
//   Directed bench for alu_mul_sequencer. It uses a table of operand and
//   product records. It also has hand-written sequences for ALU stalls,
//   ignored Start pulses, and reset in the middle of an operation.
//   The bench contains a small combinational ALU. Latency is defined
//   relative to the accept edge N. Cycle N+k is the k-th cycle after that
//   edge, and it is sampled just after its falling edge.
module tb_alu_mul_sequencer;

   localparam logic [3:0] ADD_CODE = 4'b0010;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST_N = 1'b0;
   logic        Start = 1'b0;
   logic [31:0] MulA = '0;
   logic [31:0] MulB = '0;
   logic        Busy;
   logic        Done;
   logic [31:0] Product;
   logic        AluReq;
   logic        AluGnt = 1'b1;
   logic [31:0] AluOp1;
   logic [31:0] AluOp2;
   logic [3:0]  AluCtrl;
   logic [31:0] AluRes;
   logic [1:0]  DbgState;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t vecs[10];

   // ---------------- clock ----------------
   always #5 CPU_CLK = ~CPU_CLK;

   // Shared ALU model: it adds only when asked for ADD.
   assign AluRes = (AluCtrl == ADD_CODE) ? (AluOp1 + AluOp2) : (AluOp1 ^ AluOp2);

   alu_mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .CPU_CLK  (CPU_CLK),
      .CPU_RST_N(CPU_RST_N),
      .Start    (Start),
      .MulA     (MulA),
      .MulB     (MulB),
      .Busy     (Busy),
      .Done     (Done),
      .Product  (Product),
      .AluReq   (AluReq),
      .AluGnt   (AluGnt),
      .AluOp1   (AluOp1),
      .AluOp2   (AluOp2),
      .AluCtrl  (AluCtrl),
      .AluRes   (AluRes),
      .DbgState (DbgState)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected cycles from accept to Done when the grant is held high.
   function automatic int exp_lat(input logic [31:0] b);
`ifdef MULSEQ_EARLY_EXIT_EN
      int p;
      p = 0;
      for (int i = 0; i < 32; i++) if (b[i]) p = i;
      return p + 2;
`else
      return 33 + (b == b ? 0 : 1);
`endif
   endfunction

   // ---------------- driver ----------------
   // The grant is low for cycles stall_s .. stall_s+stall_n-1.
   // Start is pulsed with MulA=MulB=1 in cycle ign_at (0 means never).
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input int stall_s, input int stall_n, input int ign_at,
                          output int lat, output logic [31:0] prod);
      int busy_bad, req_bad, freeze_bad;
      logic [31:0] p1, p2;
      busy_bad = 0; req_bad = 0; freeze_bad = 0;
      p1 = '0; p2 = '0;
      lat = -1; prod = 'x;
      @(negedge CPU_CLK);
      Start = 1'b1; MulA = a; MulB = b; AluGnt = 1'b1;
      @(posedge CPU_CLK);
      #1;
      Start = 1'b0;
      MulA = $urandom; MulB = $urandom;
      for (int k = 1; k <= 100; k++) begin
         @(negedge CPU_CLK);
         AluGnt = !(k >= stall_s && k < stall_s + stall_n);
         Start  = (k == ign_at);
         if (k == ign_at) begin
            MulA = 32'd1; MulB = 32'd1;
         end
         #1;
         if (!Busy) busy_bad++;
         if (Done) begin
            lat  = k;
            prod = Product;
            if (AluReq) req_bad++;
            break;
         end
         if (!AluReq || AluCtrl !== ADD_CODE) req_bad++;
         if (k == 1) check("first_op2", AluOp2, a);
         if (k > stall_s && k <= stall_s + stall_n &&
             (AluOp1 !== p1 || AluOp2 !== p2)) freeze_bad++;
         p1 = AluOp1; p2 = AluOp2;
      end
      @(negedge CPU_CLK);
      Start = 1'b0; AluGnt = 1'b1;
      #1;
      check("post_idle_busy", {31'd0, Busy}, 32'd0);
      check("post_idle_done", {31'd0, Done}, 32'd0);
      check("busy_window", busy_bad, 0);
      check("req_window", req_bad, 0);
      check("stall_freeze", freeze_bad, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int lat, ok;
      logic [31:0] prod;
      int done_seen;

      vecs[0] = '{32'd3,         32'd5,         32'h0000000F};
      vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
      vecs[2] = '{32'h80000000,  32'd2,         32'h00000000};
      vecs[3] = '{32'd6,         32'd7,         32'h0000002A};
      vecs[4] = '{32'h12345678,  32'd0,         32'h00000000};
      vecs[5] = '{32'h0000FFFF,  32'h00010001,  32'hFFFFFFFF};
      vecs[6] = '{32'h00010000,  32'h00010000,  32'h00000000};
      vecs[7] = '{32'h00001234,  32'h00000010,  32'h00012340};
      vecs[8] = '{32'd7,         32'd2,         32'h0000000E};
      vecs[9] = '{32'd5,         32'h80000000,  32'h80000000};

      // Reset state.
      repeat (2) @(negedge CPU_CLK);
      check("rst_busy",   {31'd0, Busy},   32'd0);
      check("rst_done",   {31'd0, Done},   32'd0);
      check("rst_prod",   Product,         32'd0);
      check("rst_req",    {31'd0, AluReq}, 32'd0);
      check("rst_op1",    AluOp1,          32'd0);
      check("rst_op2",    AluOp2,          32'd0);
      CPU_RST_N = 1'b1;
      @(negedge CPU_CLK);

      // Table-driven vectors with the grant held high.
      for (int i = 0; i < 10; i++) begin
         run_mul(vecs[i].a, vecs[i].b, 1000, 0, 0, lat, prod);
         check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].b));
         check($sformatf("vec%0d_prod", i), prod, vecs[i].p);
      end

      // Grant low for 4 cycles in the middle of STEP: 7*9.
      run_mul(32'd7, 32'd9, 2, 4, 0, lat, prod);
      check("stall_lat", lat, exp_lat(32'd9) + 4);
      check("stall_prod", prod, 32'h0000003F);

      // Start while busy, during STEP, is ignored.
      run_mul(32'd3, 32'd5, 1000, 0, 2, lat, prod);
      check("ign_step_lat", lat, exp_lat(32'd5));
      check("ign_step_prod", prod, 32'h0000000F);

      // Start in the DONE cycle is ignored (post_idle checks catch a restart).
      run_mul(32'd3, 32'd5, 1000, 0, exp_lat(32'd5), lat, prod);
      check("ign_done_lat", lat, exp_lat(32'd5));
      check("ign_done_prod", prod, 32'h0000000F);

      // Reset in the middle of STEP: outputs clear at once and no Done follows.
      @(negedge CPU_CLK);
      Start = 1'b1; MulA = 32'd3; MulB = 32'd5; AluGnt = 1'b1;
      @(posedge CPU_CLK);
      #1 Start = 1'b0;
      repeat (2) @(negedge CPU_CLK);
      #1 CPU_RST_N = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, Busy},   32'd0);
      check("mid_rst_done", {31'd0, Done},   32'd0);
      check("mid_rst_prod", Product,         32'd0);
      check("mid_rst_req",  {31'd0, AluReq}, 32'd0);
      check("mid_rst_op1",  AluOp1,          32'd0);
      check("mid_rst_op2",  AluOp2,          32'd0);
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CPU_CLK);
         if (Done || Busy) done_seen++;
      end
      CPU_RST_N = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge CPU_CLK);
         if (Done || Busy) done_seen++;
      end
      check("mid_rst_quiet", done_seen, 0);
      run_mul(32'd6, 32'd7, 1000, 0, 0, lat, prod);
      check("after_rst_lat", lat, exp_lat(32'd7));
      check("after_rst_prod", prod, 32'h0000002A);

      ok = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit: this must never be reached.
   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
